mem_access_ctrl: RTL
====================

# mem_access_ctrl

Memory-access sequencer for the SLC-3 datapath. It runs one memory read or write per request from the ISDU. For each access it drives LD_MAR, LD_MDR, the MDRmux select (MIO_EN), and the SRAM strobes, using a fixed memory latency. It also tells the ISDU which value must be gated onto the shared bus in each cycle, so the ISDU only issues start/rw and waits for done.

## Interface
- WAIT_CYCLES, default 2: number of cycles the memory strobe is held per access. Legal range is 1..15.
- Clk  in  1  system clock. All state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  access request from the ISDU. Sampled only in IDLE.
- rw  in  1  access type, 0 = read, 1 = write. Latched together with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- bus_sel  out  2  value the ISDU must gate onto the bus: 00 none, 01 address (to MAR), 10 write data (to MDR). 11 is never driven.
- LD_MAR  out  1  MAR load enable.
- LD_MDR  out  1  MDR load enable.
- MIO_EN  out  1  MDRmux select: 1 = memory data, 0 = bus.
- OE_N  out  1  SRAM output enable, active-low.
- WE_N  out  1  SRAM write enable, active-low.

## Operation
- States: IDLE, ADDR, DATA, RD, WR, DONE. The state is held in a registered FSM.
- All outputs are Moore outputs, decoded from the state and the wait counter. Any output not listed for a state is at its reset value.
- Reset values (forced asynchronously): state IDLE, busy 0, done 0, bus_sel 00, LD_MAR 0, LD_MDR 0, MIO_EN 0, OE_N 1, WE_N 1, counter 0, latched rw 0.
- IDLE:
  - If start = 1: latch rw, load the counter with WAIT_CYCLES-1, go to ADDR.
  - Otherwise stay in IDLE.
- ADDR: LD_MAR = 1, bus_sel = 01. Next state is DATA if latched rw = 1, else RD.
- DATA (write only): LD_MDR = 1, MIO_EN = 0, bus_sel = 10. Next state is WR.
- RD:
  - OE_N = 0 and MIO_EN = 1 in every RD cycle.
  - LD_MDR = 1 only when the counter = 0.
  - If the counter is not 0, decrement it and stay in RD. If it is 0, go to DONE.
- WR:
  - WE_N = 0 and MIO_EN = 0 in every WR cycle.
  - If the counter is not 0, decrement it and stay in WR. If it is 0, go to DONE.
- DONE: done = 1. Next state is always IDLE.
- The counter is 4 bits wide. It is loaded only on leaving IDLE and decremented only in RD or WR, so it never underflows.
- start is ignored in every state other than IDLE. A request is never queued.
- Changes to rw after the access has been accepted have no effect.
- OE_N and WE_N are never low in the same cycle. WE_N is never low while LD_MAR = 1.
- Reset during any state aborts the access immediately. No done pulse is produced, and strobes are released without waiting for a clock edge.

## Timing
- Take cycle 0 as the cycle in which start = 1 is sampled in IDLE.
- Read:
  - ADDR in cycle 1.
  - RD in cycles 2..1+W, where W = WAIT_CYCLES. LD_MDR is high in cycle 1+W.
  - DONE in cycle 2+W, then IDLE in cycle 3+W.
  - Read latency from start to done is 2+W cycles.
- Write:
  - ADDR in cycle 1, DATA in cycle 2.
  - WR in cycles 3..2+W.
  - DONE in cycle 3+W.
  - Write latency from start to done is 3+W cycles.
- Back-to-back requests: if start is held high, the next access is accepted in the IDLE cycle after DONE. This gives a throughput of one read every 3+W cycles.
- busy is high from cycle 1 through the DONE cycle inclusive.

## Test plan
- Reset, no start: all outputs hold their reset values; busy = 0 for 20 cycles.
- Read with W = 2, start pulsed in cycle 0:
  - LD_MAR and bus_sel = 01 in cycle 1.
  - OE_N = 0 and MIO_EN = 1 in cycles 2–3; LD_MDR = 1 in cycle 3 only.
  - done = 1 in cycle 4; IDLE in cycle 5.
- Write with W = 3, start pulsed in cycle 0:
  - LD_MAR in cycle 1.
  - LD_MDR with MIO_EN = 0 and bus_sel = 10 in cycle 2.
  - WE_N = 0 in cycles 3–5; done = 1 in cycle 6.
  - OE_N = 1 throughout.
- start held high with rw toggling every cycle, W = 1:
  - Each access uses the rw value sampled in its own IDLE cycle.
  - One done pulse per access; reads 3 cycles and writes 4 cycles start-to-done, with one IDLE cycle between accesses.
  - No start is honored while busy.
- Reset asserted mid-WR, between clock edges:
  - WE_N returns to 1 and busy to 0 asynchronously; no done pulse.
  - A new read after Reset is released completes normally.
- W = 1 and W = 15 reads: done lands exactly 3 and 17 cycles after start respectively; LD_MDR is high for exactly one cycle in each case.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - SLC-3 memory-access sequencer with fixed-latency SRAM strobes
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 2  // strobe hold cycles per access, 1..15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       rw,
  output logic       busy,
  output logic       done,
  output logic [1:0] bus_sel,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       MIO_EN,
  output logic       OE_N,
  output logic       WE_N
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_RD   = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Counter counts down to zero so the last strobe cycle is simply "counter == 0".
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_ADDR = 2'b01;
  localparam logic [1:0] BUS_WDAT = 2'b10;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       r_rw;
  logic       w_rw_next;
  logic       w_cnt_zero;

  assign w_cnt_zero = (r_cnt == 4'd0);

  // State, wait counter and latched access type; reset aborts any access at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rw    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rw    <= w_rw_next;
    end
  end

  // Next-state: start/rw only matter in IDLE, counter only moves in the strobe states.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rw_next    = r_rw;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_rw_next    = rw;
          w_cnt_next   = CNT_LOAD;
          w_state_next = S_ADDR;
        end
      end
      S_ADDR: w_state_next = r_rw ? S_DATA : S_RD;
      S_DATA: w_state_next = S_WR;
      S_RD, S_WR: begin
        if (w_cnt_zero) begin
          w_state_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Moore output decode; every output not named for a state stays at its idle value.
  always_comb begin
    busy    = (r_state != S_IDLE);
    done    = 1'b0;
    bus_sel = BUS_NONE;
    LD_MAR  = 1'b0;
    LD_MDR  = 1'b0;
    MIO_EN  = 1'b0;
    OE_N    = 1'b1;
    WE_N    = 1'b1;
    case (r_state)
      S_ADDR: begin
        LD_MAR  = 1'b1;
        bus_sel = BUS_ADDR;
      end
      S_DATA: begin
        LD_MDR  = 1'b1;
        bus_sel = BUS_WDAT;
      end
      S_RD: begin
        OE_N   = 1'b0;
        MIO_EN = 1'b1;
        // Capture memory data only on the final cycle of the read window.
        LD_MDR = w_cnt_zero;
      end
      S_WR:    WE_N = 1'b0;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
